// File: rtl/scalar_multiply_mat_seq_pkg.sv
// Shared fp_double definitions: the 64-bit IEEE-754 container type and its field widths.
package scalar_multiply_mat_seq_pkg;

  localparam int FP_W     = 64;
  localparam int FP_EXP_W = 11;
  localparam int FP_MAN_W = 52;
  localparam int FP_BIAS  = 1023;

  // Cycles from the shared multiplier's start pulse to its valid pulse.
  localparam int MUL_LATENCY = 2;

  typedef logic [FP_W-1:0] double_t;

endpackage

// File: rtl/scalar_multiply_mat_seq_if.sv
// Request/result bundle for the sequential matrix-by-scalar multiplier.
interface scalar_multiply_mat_seq_if
  import scalar_multiply_mat_seq_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8
);
  // start is a level request: it is accepted on any posedge where the block is idle
  // or done; while busy it is ignored. scale and mat are only sampled on that edge.
  logic                                start;
  double_t                             scale;
  double_t [SIZE_A-1:0][SIZE_B-1:0]    mat;
  double_t [SIZE_A-1:0][SIZE_B-1:0]    mat_out;
  logic                                busy;
  logic                                valid;
  logic [1:0]                          dbg_state;

  modport master (
    output start, scale, mat,
    input  mat_out, busy, valid, dbg_state
  );

  modport slave (
    input  start, scale, mat,
    output mat_out, busy, valid, dbg_state
  );
endinterface

// File: rtl/scalar_multiply_mat_seq_double_multiply_num.sv
// Two-stage IEEE-754 double multiplier, round-to-nearest-even; subnormals flush to zero.
module double_multiply_num
  import scalar_multiply_mat_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  input  double_t a,
  input  double_t b,
  output double_t product,
  output logic    valid
);
  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_ZERO = 2'd1;
  localparam logic [1:0] K_INF  = 2'd2;
  localparam logic [1:0] K_NAN  = 2'd3;

  logic [FP_EXP_W-1:0] ea, eb;
  logic [FP_MAN_W-1:0] fa, fb;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic                s1_valid_q, s1_valid_d;
  logic [1:0]          s1_kind_q, s1_kind_d;
  logic                s1_sign_q, s1_sign_d;
  logic signed [13:0]  s1_exp_q, s1_exp_d;
  logic [105:0]        s1_prod_q, s1_prod_d;

  double_t             product_q, product_d;
  logic                valid_q;

  assign ea = a[FP_W-2 -: FP_EXP_W];
  assign eb = b[FP_W-2 -: FP_EXP_W];
  assign fa = a[FP_MAN_W-1:0];
  assign fb = b[FP_MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  always_comb begin
    s1_valid_d = start;
    s1_sign_d  = a[FP_W-1] ^ b[FP_W-1];
    s1_prod_d  = {53'd0, 1'b1, fa} * {53'd0, 1'b1, fb};
    s1_exp_d   = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) s1_kind_d = K_NAN;
    else if (a_inf || b_inf)                                      s1_kind_d = K_INF;
    else if (a_zero || b_zero)                                    s1_kind_d = K_ZERO;
    else                                                          s1_kind_d = K_NORM;
  end

  logic [51:0]        mant;
  logic               guard, sticky, round_up;
  logic [52:0]        mant_r;
  logic signed [13:0] exp_n, exp_r;

  // The 106-bit significand product lies in [2^104, 2^106); bit 105 selects the normalising shift.
  always_comb begin
    if (s1_prod_q[105]) begin
      mant   = s1_prod_q[104:53];
      guard  = s1_prod_q[52];
      sticky = |s1_prod_q[51:0];
      exp_n  = s1_exp_q + 14'sd1;
    end else begin
      mant   = s1_prod_q[103:52];
      guard  = s1_prod_q[51];
      sticky = |s1_prod_q[50:0];
      exp_n  = s1_exp_q;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {52'd0, round_up};
    exp_r    = mant_r[52] ? (exp_n + 14'sd1) : exp_n;

    case (s1_kind_q)
      K_NAN:  product_d = 64'h7FF8_0000_0000_0000;
      K_INF:  product_d = {s1_sign_q, 11'h7FF, 52'd0};
      K_ZERO: product_d = {s1_sign_q, 63'd0};
      default: begin
        if (exp_r >= 14'sd2047)   product_d = {s1_sign_q, 11'h7FF, 52'd0};
        else if (exp_r <= 14'sd0) product_d = {s1_sign_q, 63'd0};
        else                      product_d = {s1_sign_q, exp_r[10:0], mant_r[51:0]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_kind_q  <= K_ZERO;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_prod_q  <= '0;
      product_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_kind_q  <= s1_kind_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_prod_q  <= s1_prod_d;
      product_q  <= product_d;
      valid_q    <= s1_valid_q;
    end
  end

  assign product = product_q;
  assign valid   = valid_q;

endmodule

// File: rtl/scalar_multiply_mat_seq.sv
// Scales a SIZE_A x SIZE_B double matrix by one scalar, row-major, through one shared multiplier.
module scalar_multiply_mat_seq
  import scalar_multiply_mat_seq_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  scalar_multiply_mat_seq_if.slave bus
);
  localparam int RW  = $clog2(SIZE_A) + 1;
  localparam int CW  = $clog2(SIZE_B) + 1;
  localparam int RIW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CIW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  typedef double_t [SIZE_A-1:0][SIZE_B-1:0] mat_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  double_t         scale_q, scale_d;
  mat_t            mat_q, mat_d;
  mat_t            mat_out_q, mat_out_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            mul_start_q, mul_start_d;

  logic            accept, last;
  logic [RIW-1:0]  row_idx;
  logic [CIW-1:0]  col_idx;
  double_t         mul_a, mul_product;
  logic            mul_valid;

  assign accept  = bus.start && (state_q == IDLE || state_q == DONE);
  assign last    = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign row_idx = row_q[RIW-1:0];
  assign col_idx = col_q[CIW-1:0];
  assign mul_a   = mat_q[row_idx][col_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = ISSUE;
      ISSUE:      state_d = WAIT;
      WAIT:       if (mul_valid) state_d = last ? DONE : ISSUE;
      default:    state_d = IDLE;
    endcase
  end

  // Registered start pulse coincides with the ISSUE cycle, so operands come straight from mat_q.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    scale_d     = scale_q;
    mat_d       = mat_q;
    mat_out_d   = mat_out_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    mul_start_d = (state_d == ISSUE);
    if (accept) begin
      scale_d   = bus.scale;
      mat_d     = bus.mat;
      mat_out_d = '0;
      valid_d   = 1'b0;
      busy_d    = 1'b1;
      row_d     = '0;
      col_d     = '0;
    end else if (state_q == WAIT && mul_valid) begin
      mat_out_d[row_idx][col_idx] = mul_product;
      if (last) begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      scale_q     <= '0;
      mat_q       <= '0;
      mat_out_q   <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      scale_q     <= scale_d;
      mat_q       <= mat_d;
      mat_out_q   <= mat_out_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      mul_start_q <= mul_start_d;
    end
  end

  double_multiply_num u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_q),
    .a       (mul_a),
    .b       (scale_q),
    .product (mul_product),
    .valid   (mul_valid)
  );

  assign bus.mat_out   = mat_out_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_scalar_multiply_mat_seq.sv
// Bench for scalar_multiply_mat_seq: directed table, multi-cycle corner sequences, random runs.
module tb_scalar_multiply_mat_seq;
  import scalar_multiply_mat_seq_pkg::*;

  localparam int L      = MUL_LATENCY;
  // Edges counted from the accept edge (as 1) through the edge that raises valid.
  localparam int LAT22  = 4 * (L + 1) + 1;
  localparam int LAT11  = 1 * (L + 1) + 1;
  localparam int BUDGET = 200;

  localparam double_t D_0    = 64'h0000_0000_0000_0000;
  localparam double_t D_N0   = 64'h8000_0000_0000_0000;
  localparam double_t D_1    = 64'h3FF0_0000_0000_0000;
  localparam double_t D_2    = 64'h4000_0000_0000_0000;
  localparam double_t D_3    = 64'h4008_0000_0000_0000;
  localparam double_t D_4    = 64'h4010_0000_0000_0000;
  localparam double_t D_6    = 64'h4018_0000_0000_0000;
  localparam double_t D_8    = 64'h4020_0000_0000_0000;
  localparam double_t D_HALF = 64'h3FE0_0000_0000_0000;
  localparam double_t D_1P5  = 64'h3FF8_0000_0000_0000;
  localparam double_t D_N1P5 = 64'hBFF8_0000_0000_0000;
  localparam double_t D_Q    = 64'h3FD0_0000_0000_0000;
  localparam double_t D_NQ   = 64'hBFD0_0000_0000_0000;
  localparam double_t D_N2   = 64'hC000_0000_0000_0000;
  localparam double_t D_1E10 = 64'h4202_A05F_2000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scalar_multiply_mat_seq_if #(.SIZE_A(2), .SIZE_B(2)) if22 ();
  scalar_multiply_mat_seq_if #(.SIZE_A(1), .SIZE_B(1)) if11 ();

  scalar_multiply_mat_seq #(.SIZE_A(2), .SIZE_B(2)) dut22 (.clk(clk), .rst_n(rst_n), .bus(if22.slave));
  scalar_multiply_mat_seq #(.SIZE_A(1), .SIZE_B(1)) dut11 (.clk(clk), .rst_n(rst_n), .bus(if11.slave));

  typedef struct packed {
    double_t       scale;
    double_t [3:0] m;
    double_t [3:0] e;
  } vec_t;

  vec_t              tbl [3];
  logic [63:0]       exp_q [$];
  int                total = 0;
  int                bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference: the host's IEEE double multiply (round-to-nearest-even).
  function automatic double_t ref_mul(input double_t a, input double_t b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  // Exponents kept near the bias so every product stays a normal number.
  function automatic double_t rand_double();
    logic [10:0] e;
    logic [51:0] m;
    e = 11'($urandom_range(1023 - 200, 1023 + 200));
    m = {20'($urandom), $urandom};
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  task automatic scribble22();
    if22.scale = rand_double();
    for (int i = 0; i < 4; i++) if22.mat[i/2][i%2] = rand_double();
  endtask

  // Presents a request, lets it be accepted, then corrupts the inputs right away.
  task automatic launch22(input string name, input double_t sc, input double_t [3:0] m);
    @(negedge clk);
    if22.start = 1'b1;
    if22.scale = sc;
    for (int i = 0; i < 4; i++) if22.mat[i/2][i%2] = m[i];
    @(negedge clk);
    if22.start = 1'b0;
    scribble22();
    check({name, "_busy_on_accept"}, 64'(if22.busy), 64'd1);
    check({name, "_valid_on_accept"}, 64'(if22.valid), 64'd0);
  endtask

  task automatic wait_valid22(input int cyc0, output int cyc);
    cyc = cyc0;
    while (if22.valid !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish22(input string name, input int cyc0);
    int cyc;
    wait_valid22(cyc0, cyc);
    check({name, "_latency"}, 64'(cyc), 64'(LAT22));
    check({name, "_busy_done"}, 64'(if22.busy), 64'd0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("%s_out[%0d][%0d]", name, r, c), if22.mat_out[r][c], exp_q.pop_front());
  endtask

  task automatic push_exp(input double_t [3:0] e);
    for (int i = 0; i < 4; i++) exp_q.push_back(e[i]);
  endtask

  initial begin
    int cyc;
    double_t sc;
    double_t [3:0] m;

    tbl[0] = '{scale: D_2, m: {D_4, D_3, D_2, D_1},        e: {D_8, D_6, D_4, D_2}};
    tbl[1] = '{scale: D_1, m: {D_N0, D_1E10, D_Q, D_N1P5}, e: {D_N0, D_1E10, D_Q, D_N1P5}};
    tbl[2] = '{scale: D_0, m: {D_3, D_NQ, D_N2, D_1},      e: {D_0, D_N0, D_N0, D_0}};

    rst_n = 1'b0;
    if22.start = 1'b0; if22.scale = '0; if22.mat = '0;
    if11.start = 1'b0; if11.scale = '0; if11.mat = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", 64'(if22.valid), 64'd0);
    check("reset_busy", 64'(if22.busy), 64'd0);
    check("reset_state", 64'(if22.dbg_state), 64'd0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("reset_out[%0d][%0d]", r, c), if22.mat_out[r][c], 64'd0);

    for (int v = 0; v < 3; v++) begin
      push_exp(tbl[v].e);
      launch22($sformatf("tbl%0d", v), tbl[v].scale, tbl[v].m);
      finish22($sformatf("tbl%0d", v), 1);
    end

    // start pulsed mid-run must not disturb the run in progress.
    push_exp(tbl[0].e);
    launch22("busy_pulse", tbl[0].scale, tbl[0].m);
    repeat (3) @(negedge clk);
    if22.start = 1'b1;
    if22.scale = D_3;
    if22.mat   = {D_8, D_8, D_8, D_8};
    @(negedge clk);
    if22.start = 1'b0;
    finish22("busy_pulse", 5);

    // A fresh start from DONE drops valid at once and runs with the new operands.
    push_exp(tbl[1].e);
    launch22("done_restart", tbl[1].scale, tbl[1].m);
    finish22("done_restart", 1);

    // Reset while element 3 is in flight.
    launch22("midrst", tbl[0].scale, tbl[0].m);
    repeat (3 * (L + 1) + 1) @(negedge clk);
    check("midrst_in_wait", 64'(if22.dbg_state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(if22.valid), 64'd0);
    check("midrst_busy", 64'(if22.busy), 64'd0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("midrst_out[%0d][%0d]", r, c), if22.mat_out[r][c], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(tbl[0].e);
    launch22("after_rst", tbl[0].scale, tbl[0].m);
    finish22("after_rst", 1);

    // 1x1 instance, then start held high across DONE re-triggers each time.
    @(negedge clk);
    if11.start = 1'b1; if11.scale = D_3; if11.mat[0][0] = D_HALF;
    @(negedge clk);
    if11.start = 1'b0; if11.scale = rand_double(); if11.mat[0][0] = rand_double();
    cyc = 1;
    while (if11.valid !== 1'b1 && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("one_latency", 64'(cyc), 64'(LAT11));
    check("one_out", if11.mat_out[0][0], D_1P5);
    if11.start = 1'b1; if11.scale = D_2; if11.mat[0][0] = D_HALF;
    @(negedge clk);
    check("one_hold_drop", 64'(if11.valid), 64'd0);
    cyc = 1;
    while (if11.valid !== 1'b1 && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("one_hold_latency", 64'(cyc), 64'(LAT11));
    check("one_hold_out", if11.mat_out[0][0], D_1);
    @(negedge clk);
    check("one_hold_retrigger", 64'(if11.valid), 64'd0);
    if11.start = 1'b0;

    for (int k = 0; k < 8; k++) begin
      sc = rand_double();
      for (int i = 0; i < 4; i++) begin
        m[i] = rand_double();
        exp_q.push_back(ref_mul(m[i], sc));
      end
      launch22($sformatf("rnd%0d", k), sc, m);
      finish22($sformatf("rnd%0d", k), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
